dut_initiator: RTL and testbench

Bus initiator for the 1-bit AND-gate DUT's register-mapped write/read method interface. It takes operand jobs (a, b) on a valid/ready port and drives the DUT's write and read methods, enable plus ready, as a master. It polls FIFO status, writes both operands, waits for the result and returns it on a valid/ready result port. It is the driving end of the interface that the DUT exposes, and replaces testbench-driven bus stimulus in integrated builds.

---
 rtl/dut_initiator.sv | 156 +++++++++++++++
 tb/tb_dut_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_initiator.sv
// Bus initiator for the AND-gate DUT: polls FIFO status, writes operands A and B,
// reads back Y and returns it on a valid/ready result port.
module dut_initiator #(
  parameter int unsigned POLL_LIMIT = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic       job_a,
  input  logic       job_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_y,
  output logic       res_err,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(POLL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_A, S_WR_A, S_POLL_B, S_WR_B, S_POLL_Y, S_RD_Y, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_q, a_d, b_q, b_d;
  logic               y_q, y_d, err_q, err_d;
  logic [CNT_W:0]     cnt_inc;
  logic               rd_done;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign rd_done = read_rdy && read_data;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          a_d     = job_a;
          b_d     = job_b;
          y_d     = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_POLL_A;
        end
      end
      S_POLL_A, S_POLL_B, S_POLL_Y: begin
        if (read_rdy) begin
          if (rd_done) begin
            cnt_d = '0;
            case (state_q)
              S_POLL_A: state_d = S_WR_A;
              S_POLL_B: state_d = S_WR_B;
              default:  state_d = S_RD_Y;
            endcase
          end else if (cnt_inc >= LIMIT) begin
            // Timeout: already-written operands are not rolled back
            cnt_d   = '0;
            y_d     = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
      end
      S_WR_A: begin
        if (write_rdy) begin
          cnt_d   = '0;
          state_d = S_POLL_B;
        end
      end
      S_WR_B: begin
        if (write_rdy) begin
          cnt_d   = '0;
          state_d = S_POLL_Y;
        end
      end
      S_RD_Y: begin
        if (read_rdy) begin
          y_d     = read_data;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    job_ready     = 1'b0;
    res_valid     = 1'b0;
    res_y         = 1'b0;
    res_err       = 1'b0;
    write_address = 3'd0;
    write_data    = 1'b0;
    write_en      = 1'b0;
    read_address  = 3'd0;
    read_en       = 1'b0;
    case (state_q)
      S_IDLE:   job_ready = 1'b1;
      S_POLL_A: begin read_en = 1'b1; read_address = 3'd0; end
      S_POLL_B: begin read_en = 1'b1; read_address = 3'd1; end
      S_POLL_Y: begin read_en = 1'b1; read_address = 3'd2; end
      S_RD_Y:   begin read_en = 1'b1; read_address = 3'd3; end
      S_WR_A:   begin write_en = 1'b1; write_address = 3'd4; write_data = a_q; end
      S_WR_B:   begin write_en = 1'b1; write_address = 3'd5; write_data = b_q; end
      S_RESP: begin
        res_valid = 1'b1;
        res_y     = y_q;
        res_err   = err_q;
      end
      default: job_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dut_initiator.sv
// Directed bench for dut_initiator: a behavioural AND-gate DUT model answers the bus;
// a second instance with POLL_LIMIT=4 covers the timeout path.
module tb_dut_initiator;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic sel;
  logic job_valid, job_a, job_b, res_ready;
  logic write_rdy, read_data, read_rdy;

  logic jr0, rv0, ry0, re0, wd0, we0, ren0;
  logic [2:0] wa0, ra0;
  logic jr1, rv1, ry1, re1, wd1, we1, ren1;
  logic [2:0] wa1, ra1;

  logic m_job_ready, m_res_valid, m_res_y, m_res_err, m_write_data, m_write_en, m_read_en;
  logic [2:0] m_write_address, m_read_address;

  dut_initiator #(.POLL_LIMIT(16)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .job_valid(job_valid & ~sel), .job_ready(jr0), .job_a(job_a), .job_b(job_b),
    .res_valid(rv0), .res_ready(res_ready & ~sel), .res_y(ry0), .res_err(re0),
    .write_address(wa0), .write_data(wd0), .write_en(we0), .write_rdy(write_rdy),
    .read_address(ra0), .read_en(ren0), .read_data(read_data), .read_rdy(read_rdy)
  );

  dut_initiator #(.POLL_LIMIT(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N),
    .job_valid(job_valid & sel), .job_ready(jr1), .job_a(job_a), .job_b(job_b),
    .res_valid(rv1), .res_ready(res_ready & sel), .res_y(ry1), .res_err(re1),
    .write_address(wa1), .write_data(wd1), .write_en(we1), .write_rdy(write_rdy),
    .read_address(ra1), .read_en(ren1), .read_data(read_data), .read_rdy(read_rdy)
  );

  assign m_job_ready     = sel ? jr1  : jr0;
  assign m_res_valid     = sel ? rv1  : rv0;
  assign m_res_y         = sel ? ry1  : ry0;
  assign m_res_err       = sel ? re1  : re0;
  assign m_write_address = sel ? wa1  : wa0;
  assign m_write_data    = sel ? wd1  : wd0;
  assign m_write_en      = sel ? we1  : we0;
  assign m_read_address  = sel ? ra1  : ra0;
  assign m_read_en       = sel ? ren1 : ren0;

  // DUT model knobs (driven by tests) and counters (driven by the monitor)
  logic a_stuck;
  int   y_zero_cfg, y_base, y_total;
  int   wstall_cfg, wb_base, wb_total;
  logic ma, mb;
  int   log_n;
  int   log_addr [0:1023];
  int   log_dat  [0:1023];
  logic overlap, hold_err, prev_wst, p_wd;
  logic [2:0] p_wa;

  assign read_rdy  = 1'b1;
  assign write_rdy = !(m_write_en && m_write_address == 3'd5 && (wb_total - wb_base) < wstall_cfg);

  always_comb begin
    read_data = 1'b0;
    case (m_read_address)
      3'd0: read_data = !a_stuck;
      3'd1: read_data = 1'b1;
      3'd2: read_data = (y_total - y_base) >= y_zero_cfg;
      3'd3: read_data = ma & mb;
      default: read_data = 1'b0;
    endcase
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ma <= 1'b0; mb <= 1'b0; log_n <= 0; y_total <= 0; wb_total <= 0;
      overlap <= 1'b0; hold_err <= 1'b0; prev_wst <= 1'b0; p_wa <= 3'd0; p_wd <= 1'b0;
    end else begin
      if (m_write_en && m_read_en) overlap <= 1'b1;
      if (prev_wst && !(m_write_en && m_write_address == p_wa && m_write_data == p_wd)) hold_err <= 1'b1;
      prev_wst <= m_write_en && !write_rdy;
      p_wa <= m_write_address;
      p_wd <= m_write_data;
      if (m_write_en && m_write_address == 3'd5) wb_total <= wb_total + 1;
      if (m_write_en && write_rdy) begin
        if (m_write_address == 3'd4) ma <= m_write_data;
        if (m_write_address == 3'd5) mb <= m_write_data;
        log_addr[log_n] <= int'(m_write_address);
        log_dat[log_n]  <= int'(m_write_data);
        log_n <= log_n + 1;
      end else if (m_read_en && read_rdy) begin
        if (m_read_address == 3'd2) y_total <= y_total + 1;
        log_addr[log_n] <= int'(m_read_address);
        log_dat[log_n]  <= int'(read_data);
        log_n <= log_n + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Drives one job and collects latency and result; no checking here
  task automatic do_job(input logic a, input logic b, input int hold,
                        output int lat, output logic y, output logic err, output logic held_ok);
    int k;
    k = 0;
    @(negedge CLK);
    while (!m_job_ready && k < 50) begin @(negedge CLK); k++; end
    job_valid = 1'b1; job_a = a; job_b = b;
    @(negedge CLK);
    job_valid = 1'b0;
    lat = 1;
    while (!m_res_valid && lat < 300) begin @(negedge CLK); lat++; end
    y = m_res_y; err = m_res_err; held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (!m_res_valid || m_res_y !== y || m_res_err !== err) held_ok = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    logic act;
    int base;
    #1;
    obs = {m_job_ready, m_res_valid, m_res_y, m_res_err, m_write_address, m_write_data,
           m_write_en, m_read_address, m_read_en};
    checks++; if (obs !== 13'h1000) begin errors++; $display("FAIL reset_state got %h exp %h", obs, 13'h1000); end
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK); job_valid = 1'b1; job_a = 1'b1; job_b = 1'b1;
    @(negedge CLK); job_valid = 1'b0;
    @(negedge CLK);
    checks++; if (!(m_write_en === 1'b1 && m_write_address === 3'd4)) begin
      errors++; $display("FAIL reset_wr_a_reached got we=%b addr=%0d exp we=1 addr=4", m_write_en, m_write_address); end
    #2 RST_N = 1'b0;
    #1;
    obs = {m_job_ready, m_res_valid, m_res_y, m_res_err, m_write_address, m_write_data,
           m_write_en, m_read_address, m_read_en};
    checks++; if (obs !== 13'h1000) begin errors++; $display("FAIL reset_mid_job got %h exp %h", obs, 13'h1000); end
    @(negedge CLK); RST_N = 1'b1;
    base = log_n; act = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (m_write_en || m_read_en || m_res_valid || !m_job_ready) act = 1'b1;
    end
    checks++; if (act !== 1'b0 || log_n != base) begin
      errors++; $display("FAIL reset_idle got act=%b ops=%0d exp act=0 ops=0", act, log_n - base); end
  endtask

  task automatic test_truth();
    int exp_addr [0:5];
    int lat, base;
    logic y, err, held, a, b, seq_ok;
    exp_addr = '{0, 4, 1, 5, 2, 3};
    for (int i = 0; i < 4; i++) begin
      a = (i >= 2); b = (i % 2 == 1);
      base = log_n;
      do_job(a, b, 0, lat, y, err, held);
      checks++; if (y !== (a & b) || err !== 1'b0) begin
        errors++; $display("FAIL truth_y%0d got y=%b err=%b exp y=%b err=0", i, y, err, a & b); end
      checks++; if (lat != 7) begin errors++; $display("FAIL truth_lat%0d got %0d exp 7", i, lat); end
      seq_ok = (log_n - base == 6);
      for (int k = 0; k < 6; k++) if (seq_ok && log_addr[base+k] != exp_addr[k]) seq_ok = 1'b0;
      if (seq_ok && (log_dat[base+1] != int'(a) || log_dat[base+3] != int'(b))) seq_ok = 1'b0;
      checks++; if (seq_ok !== 1'b1) begin
        errors++; $display("FAIL truth_bus%0d got ops=%0d first_addr=%0d exp ops=6 seq 0,4,1,5,2,3", i, log_n - base, log_addr[base]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic y, err, held;
    wb_base = wb_total; wstall_cfg = 3;
    do_job(1'b1, 1'b1, 4, lat, y, err, held);
    checks++; if (lat != 10) begin errors++; $display("FAIL bp_latency got %0d exp 10", lat); end
    checks++; if (wb_total - wb_base != 4) begin errors++; $display("FAIL bp_wrb_cycles got %0d exp 4", wb_total - wb_base); end
    checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL bp_write_hold got %b exp 0", hold_err); end
    checks++; if (held !== 1'b1 || y !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL bp_result_hold got held=%b y=%b err=%b exp 1 1 0", held, y, err); end
    wstall_cfg = 0;
  endtask

  task automatic test_slow_result();
    int lat, base, n2, n3;
    logic y, err, held;
    y_base = y_total; y_zero_cfg = 5; base = log_n;
    do_job(1'b1, 1'b1, 0, lat, y, err, held);
    n2 = 0; n3 = 0;
    for (int k = base; k < log_n; k++) begin
      if (log_addr[k] == 2) n2++;
      if (log_addr[k] == 3 && n2 == 6) n3++;
    end
    checks++; if (n2 != 6 || n3 != 1) begin errors++; $display("FAIL slow_reads got y_status=%0d y_data=%0d exp 6 1", n2, n3); end
    checks++; if (y !== 1'b1 || err !== 1'b0 || lat != 12) begin
      errors++; $display("FAIL slow_result got y=%b err=%b lat=%0d exp 1 0 12", y, err, lat); end
    y_zero_cfg = 0;
  endtask

  task automatic test_timeout();
    int lat, base, n0;
    logic y, err, held;
    @(negedge CLK); sel = 1'b1; a_stuck = 1'b1; base = log_n;
    do_job(1'b1, 1'b1, 0, lat, y, err, held);
    n0 = 0;
    for (int k = base; k < log_n; k++) if (log_addr[k] == 0) n0++;
    checks++; if (n0 != 4 || log_n - base != 4) begin
      errors++; $display("FAIL timeout_reads got a_status=%0d ops=%0d exp 4 4", n0, log_n - base); end
    checks++; if (err !== 1'b1 || y !== 1'b0 || lat != 5) begin
      errors++; $display("FAIL timeout_result got err=%b y=%b lat=%0d exp 1 0 5", err, y, lat); end
    a_stuck = 1'b0;
    do_job(1'b1, 1'b1, 0, lat, y, err, held);
    checks++; if (err !== 1'b0 || y !== 1'b1 || lat != 7) begin
      errors++; $display("FAIL timeout_next_job got err=%b y=%b lat=%0d exp 0 1 7", err, y, lat); end
    @(negedge CLK); sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ja [0:2];
    logic jb [0:2];
    logic got [0:2];
    int acc_c [0:2];
    int resp_c [0:2];
    int idx, rcv;
    logic conflict, tim_ok;
    ja = '{1'b1, 1'b0, 1'b1}; jb = '{1'b1, 1'b1, 1'b0};
    idx = 0; rcv = 0; conflict = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 80 && rcv < 3; c++) begin
      @(negedge CLK);
      if (m_res_valid && m_job_ready) conflict = 1'b1;
      if (m_res_valid) begin got[rcv] = m_res_y; resp_c[rcv] = c; rcv++; end
      if (m_job_ready) begin
        if (idx < 3) begin
          job_valid = 1'b1; job_a = ja[idx]; job_b = jb[idx]; acc_c[idx] = c; idx++;
        end else job_valid = 1'b0;
      end
    end
    job_valid = 1'b0; res_ready = 1'b0;
    checks++; if (rcv != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", rcv); end
    tim_ok = (rcv == 3) && (idx == 3);
    for (int k = 0; k < 3; k++) if (tim_ok && resp_c[k] != acc_c[k] + 7) tim_ok = 1'b0;
    for (int k = 0; k < 2; k++) if (tim_ok && acc_c[k+1] != resp_c[k] + 1) tim_ok = 1'b0;
    checks++; if (tim_ok !== 1'b1) begin errors++; $display("FAIL b2b_timing got ok=%b exp 1", tim_ok); end
    checks++; if (rcv == 3 && {got[0], got[1], got[2]} !== 3'b100) begin
      errors++; $display("FAIL b2b_results got %b%b%b exp 100", got[0], got[1], got[2]); end
    checks++; if (conflict !== 1'b0 || overlap !== 1'b0) begin
      errors++; $display("FAIL b2b_exclusive got conflict=%b overlap=%b exp 0 0", conflict, overlap); end
  endtask

  initial begin
    RST_N = 1'b0; sel = 1'b0;
    job_valid = 1'b0; job_a = 1'b0; job_b = 1'b0; res_ready = 1'b0;
    a_stuck = 1'b0; y_zero_cfg = 0; y_base = 0; wstall_cfg = 0; wb_base = 0;
    test_reset();
    test_truth();
    test_backpressure();
    test_slow_result();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
